// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
package whack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int unsigned LFSR_W    = 8;
  // Feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  localparam logic [7:0] BCD_ZERO = 8'h00;
  localparam logic [7:0] BCD_ONE  = 8'h01;
  localparam logic [7:0] BCD_MAX  = 8'h99;

  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD register with synchronous load, increment and decrement,
// saturating at 00 and 99. Load has priority over inc, inc over dec.
module bcd_counter2
  import whack_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] value
);

  logic [3:0] tens;
  logic [3:0] ones;
  logic [7:0] inc_value;
  logic [7:0] dec_value;

  assign tens = value[7:4];
  assign ones = value[3:0];

  // Digit-wise carry/borrow; held value at either end of the range
  always_comb begin
    inc_value = value;
    dec_value = value;
    if (value != BCD_MAX) begin
      if (ones == 4'd9) inc_value = {tens + 4'd1, 4'd0};
      else              inc_value = {tens, ones + 4'd1};
    end
    if (value != BCD_ZERO) begin
      if (ones == 4'd0) dec_value = {tens - 4'd1, 4'd9};
      else              dec_value = {tens, ones - 4'd1};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= BCD_ZERO;
    end else if (load) begin
      value <= load_value;
    end else if (inc) begin
      value <= inc_value;
    end else if (dec) begin
      value <= dec_value;
    end
  end

endmodule

// File: rtl/whack_round_controller.sv
// Timed whack-a-mole round: 1 Hz tick detection, LFSR mole placement,
// hit scoring and BCD time/score outputs.
module whack_round_controller
  import whack_pkg::*;
#(
  parameter int unsigned ROUND_SECONDS = 30,
  parameter int unsigned NUM_MOLES     = 4,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 slow_clock,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] hit,
  output logic [NUM_MOLES-1:0] mole_onehot,
  output logic [7:0]           time_bcd,
  output logic [7:0]           score_bcd,
  output logic                 running,
  output logic                 game_over
);

  localparam int unsigned IDX_W     = $clog2(NUM_MOLES);
  localparam logic [7:0]  ROUND_BCD = to_bcd(ROUND_SECONDS);

  state_t              state_q;
  state_t              state_d;
  logic                slow_q;
  logic                tick;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [IDX_W-1:0]    cur_idx_q;
  logic [IDX_W-1:0]    cand;
  logic [IDX_W-1:0]    next_idx;
  logic [NUM_MOLES-1:0] next_onehot;
  logic                correct_hit;

  logic time_load;
  logic time_dec;
  logic score_load;
  logic score_inc;
  logic score_dec;
  logic mole_light;
  logic mole_clear;

  assign tick = slow_clock & ~slow_q;

  // Never light the same position twice in a row
  assign cand        = lfsr_q[IDX_W-1:0];
  assign next_idx    = (cand == cur_idx_q) ? IDX_W'(cand + IDX_W'(1)) : cand;
  assign next_onehot = NUM_MOLES'(1) << next_idx;
  assign correct_hit = (mole_onehot != '0) && (hit == mole_onehot);

  // Next state and datapath controls
  always_comb begin
    state_d    = state_q;
    time_load  = 1'b0;
    time_dec   = 1'b0;
    score_load = 1'b0;
    score_inc  = 1'b0;
    score_dec  = 1'b0;
    mole_light = 1'b0;
    mole_clear = 1'b0;
    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d    = PLAY;
          time_load  = 1'b1;
          score_load = 1'b1;
          mole_light = 1'b1;
        end
      end
      PLAY: begin
        if (hit != '0) begin
          if (correct_hit) begin
            score_inc  = 1'b1;
            mole_clear = 1'b1;
          end else begin
            score_dec  = 1'b1;
          end
        end
        // A tick's fresh mole overrides a same-cycle hit clear
        if (tick) begin
          time_dec = 1'b1;
          if (time_bcd == BCD_ONE) begin
            mole_clear = 1'b1;
            state_d    = OVER;
          end else begin
            mole_light = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      running   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state_q   <= state_d;
      running   <= (state_d == PLAY);
      game_over <= (state_d == OVER);
    end
  end

  // LFSR free-runs in every state so start timing perturbs placement
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slow_q      <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      cur_idx_q   <= '0;
      mole_onehot <= '0;
    end else begin
      slow_q <= slow_clock;
      lfsr_q <= lfsr_step(lfsr_q);
      if (mole_light) begin
        mole_onehot <= next_onehot;
        cur_idx_q   <= next_idx;
      end else if (mole_clear) begin
        mole_onehot <= '0;
      end
    end
  end

  bcd_counter2 u_time (
    .clock      (clock),
    .reset      (reset),
    .load       (time_load),
    .load_value (ROUND_BCD),
    .inc        (1'b0),
    .dec        (time_dec),
    .value      (time_bcd)
  );

  bcd_counter2 u_score (
    .clock      (clock),
    .reset      (reset),
    .load       (score_load),
    .load_value (BCD_ZERO),
    .inc        (score_inc),
    .dec        (score_dec),
    .value      (score_bcd)
  );

endmodule
